// File: rtl/fpu_issue_pkg.sv
// fpu_issue_pkg: definitions shared by the FPU issue block and its bench.
//   FPU_OP_W / FPU_RD_W : default opcode and register-index widths
//   FPU_OP_NOP / FPU_OP_FADD : FPU opcode encodings (0 is never issued)
//   state_t : issue state machine encoding
package fpu_issue_pkg;

  localparam int FPU_OP_W = 4;
  localparam int FPU_RD_W = 5;

  localparam logic [FPU_OP_W-1:0] FPU_OP_NOP  = 4'd0;
  localparam logic [FPU_OP_W-1:0] FPU_OP_FADD = 4'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARMED = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fpu_issue.sv
// fpu_issue: requester side of the FPU handshake. It takes one FP operation
// from the pipeline, holds opcode and operands steady on the FPU until the
// FPU reports ready, then emits a one-cycle writeback to the FP register file.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   req_valid/req_ready        pipeline request handshake (ready only in IDLE)
//   req_op/req_a/req_b/req_rd  opcode, operands, destination (sampled on accept)
//   fpu_ctl/fpu_x1/fpu_x2      opcode and operands to the FPU (ctl=0 when idle)
//   fpu_y/fpu_ready            FPU result and level-type result-valid
//   wb_valid/wb_rd/wb_data     one-cycle writeback strobe, index, value
//   busy                       an operation is outstanding (pipeline stall)
//   err                        timeout abort pulse (FPU_ISSUE_TIMEOUT_EN only)
//
// Build option
//   FPU_ISSUE_TIMEOUT_EN : when defined, adds the TIMEOUT parameter, an ARMED
//   cycle counter and the err output; ARMED aborts after TIMEOUT cycles
//   without fpu_ready. When undefined, ARMED waits indefinitely.
module fpu_issue
  import fpu_issue_pkg::*;
#(
  parameter int OP_W = FPU_OP_W,
  parameter int RD_W = FPU_RD_W
`ifdef FPU_ISSUE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [RD_W-1:0] req_rd,
  output logic [OP_W-1:0] fpu_ctl,
  output logic [31:0]     fpu_x1,
  output logic [31:0]     fpu_x2,
  input  logic [31:0]     fpu_y,
  input  logic            fpu_ready,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            busy
`ifdef FPU_ISSUE_TIMEOUT_EN
  ,
  output logic            err
`endif
);

  state_t          state;
  state_t          state_next;
  logic [RD_W-1:0] rd_q;
  logic            accept;
  logic            result_hit;
  logic            timeout_hit;

  // A request with opcode 0 is consumed as a no-op: it never leaves IDLE.
  assign accept     = req_ready && req_valid && (req_op != '0);
  // fpu_ready is only trusted in ARMED; in ISSUE it may still be the
  // previous op's level-high ready.
  assign result_hit = (state == ARMED) && fpu_ready;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = ARMED;
      ARMED: begin
        if (result_hit)       state_next = DONE;
        else if (timeout_hit) state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic: the pipeline may only hand over a request in IDLE.
  // ---------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    if (state == IDLE) req_ready = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Datapath registers. Operands are only loaded on acceptance, so they
  // cannot move while fpu_ctl is nonzero.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fpu_ctl  <= '0;
      fpu_x1   <= '0;
      fpu_x2   <= '0;
      rd_q     <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      busy     <= 1'b0;
    end else begin
      // High exactly for the DONE cycle.
      wb_valid <= result_hit;

      if (accept) begin
        fpu_ctl <= req_op;
        fpu_x1  <= req_a;
        fpu_x2  <= req_b;
        rd_q    <= req_rd;
        busy    <= 1'b1;
      end

      if (result_hit) begin
        wb_data <= fpu_y;
        wb_rd   <= rd_q;
        fpu_ctl <= '0;
      end

      if (state == DONE) busy <= 1'b0;

      // Abort: release the FPU and the pipeline without a writeback.
      if (timeout_hit) begin
        fpu_ctl <= '0;
        busy    <= 1'b0;
      end
    end
  end

`ifdef FPU_ISSUE_TIMEOUT_EN
  // ---------------------------------------------------------------------
  // Timeout: tmo_cnt holds the number of completed ARMED cycles. The abort
  // fires in the ARMED cycle that would bring it to TIMEOUT; a result seen
  // in that same cycle takes priority through result_hit.
  // ---------------------------------------------------------------------
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] tmo_cnt;

  assign timeout_hit = (state == ARMED) && !fpu_ready &&
                       (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      err <= timeout_hit;
      if (accept) begin
        tmo_cnt <= '0;
      end else if (state == ARMED) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: self-checking bench for fpu_issue. A small behavioural FPU
// answers each issued op after a programmable delay and keeps ready high
// afterwards (level semantics). Table rows cover single ops; hand-written
// sequences cover idle/no-op, back-to-back, reset mid-op and, when
// FPU_ISSUE_TIMEOUT_EN is defined, the timeout abort.
module tb_fpu_issue;
  import fpu_issue_pkg::*;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic [3:0]  fpu_ctl;
  logic [31:0] fpu_x1;
  logic [31:0] fpu_x2;
  logic [31:0] fpu_y;
  logic        fpu_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
`ifdef FPU_ISSUE_TIMEOUT_EN
  logic        err;
`endif

  int checks   = 0;
  int failures = 0;

  fpu_issue dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rd    (req_rd),
    .fpu_ctl   (fpu_ctl),
    .fpu_x1    (fpu_x1),
    .fpu_x2    (fpu_x2),
    .fpu_y     (fpu_y),
    .fpu_ready (fpu_ready),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .busy      (busy)
`ifdef FPU_ISSUE_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------
  // Behavioural FPU: on the first edge that sees a nonzero ctl it drops
  // ready (or answers at once when m_delay is 0); ready then rises m_delay
  // edges later with m_res and stays high until the next op is sampled.
  // -------------------------------------------------------------------
  int          m_delay   = 0;
  logic [31:0] m_res     = '0;
  logic        stale_set = 1'b0;
  int          m_cnt;
  logic        m_active;

  always @(posedge clk) begin
    if (!rstn) begin
      fpu_ready <= 1'b0;
      fpu_y     <= '0;
      m_active  <= 1'b0;
      m_cnt     <= 0;
    end else if (stale_set) begin
      fpu_ready <= 1'b1;
      fpu_y     <= 32'hDEADBEEF;
      m_active  <= 1'b0;
    end else if (fpu_ctl != 4'd0 && !m_active) begin
      m_active <= 1'b1;
      m_cnt    <= m_delay;
      if (m_delay == 0) begin
        fpu_ready <= 1'b1;
        fpu_y     <= m_res;
      end else begin
        fpu_ready <= 1'b0;
      end
    end else if (m_active && fpu_ctl != 4'd0 && m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        fpu_ready <= 1'b1;
        fpu_y     <= m_res;
      end
    end else if (fpu_ctl == 4'd0) begin
      m_active <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------
  // Table of single operations. exp_lat counts clock edges from the
  // accepting edge (inclusive) to the cycle showing wb_valid:
  // 3 + m_delay.
  // -------------------------------------------------------------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          delay;
    bit          stale;
    bit          hold;
    int          exp_lat;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v);
    int n;
    int got_lat;
    int bad_hold;
    m_res   = v.res;
    m_delay = v.delay;
    if (v.stale) begin
      stale_set = 1'b1;
      @(negedge clk);
      stale_set = 1'b0;
    end
    req_op    = FPU_OP_FADD;
    req_a     = v.a;
    req_b     = v.b;
    req_rd    = v.rd;
    req_valid = 1'b1;
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    n = 1;
    if (v.hold) begin
      // A different request stays asserted while busy; it must be ignored.
      req_a  = ~v.a;
      req_b  = ~v.b;
      req_rd = 5'd30;
    end else begin
      req_valid = 1'b0;
    end
    got_lat  = -1;
    bad_hold = 0;
    while (n < 60 && got_lat < 0) begin
      if (wb_valid) begin
        got_lat = n;
      end else begin
        if (fpu_ctl != FPU_OP_FADD || fpu_x1 != v.a || fpu_x2 != v.b ||
            !busy || req_ready)
          bad_hold++;
        @(negedge clk);
        n++;
      end
    end
    req_valid = 1'b0;
    check("op_latency", got_lat, v.exp_lat);
    check("wb_rd", {27'd0, wb_rd}, {27'd0, v.exp_rd});
    check("wb_data", wb_data, v.exp_data);
    check("ctl_operands_held_while_busy", bad_hold, 0);
    check("req_ready_low_in_done", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("wb_valid_single_cycle", {31'd0, wb_valid}, 32'd0);
    check("busy_clear_after_done", {31'd0, busy}, 32'd0);
    check("fpu_ctl_idle", {28'd0, fpu_ctl}, 32'd0);
    check("wb_data_holds", wb_data, v.exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    int p1_n;
    int p2_n;
    logic [4:0]  p1_rd;
    logic [4:0]  p2_rd;
    logic [31:0] p1_data;
    logic [31:0] p2_data;
    int ctl_zero;
    int bad;

    //          a             b             rd     res           dly st hold lat exp_rd exp_data
    vecs[0] = '{32'h3F800000, 32'h40000000, 5'd3,  32'h40400000, 1, 1, 0,  4, 5'd3,  32'h40400000};
    vecs[1] = '{32'h40400000, 32'h3F800000, 5'd7,  32'h40800000, 7, 0, 1, 10, 5'd7,  32'h40800000};
    vecs[2] = '{32'h40A00000, 32'hC0000000, 5'd31, 32'h40400000, 0, 0, 0,  3, 5'd31, 32'h40400000};
    vecs[3] = '{32'h00000000, 32'h00000000, 5'd0,  32'h00000000, 2, 0, 0,  5, 5'd0,  32'h00000000};

    rstn      = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_rd    = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Idle after reset: ready, not busy, FPU idle, no writeback.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready_busy_wb", {29'd0, req_ready, busy, wb_valid}, 32'h4);
      check("idle_fpu_ctl", {28'd0, fpu_ctl}, 32'd0);
    end

    // Opcode 0 is consumed as a no-op.
    req_valid = 1'b1;
    req_op    = FPU_OP_NOP;
    req_a     = 32'h12345678;
    req_rd    = 5'd9;
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    check("nop_no_busy", {30'd0, busy, wb_valid}, 32'd0);
    check("nop_ctl_stays_zero", {28'd0, fpu_ctl}, 32'd0);
    check("nop_req_ready", {31'd0, req_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: request held high across two fadds (rd=1, then rd=2).
    m_delay   = 0;
    m_res     = 32'h40400000;
    req_op    = FPU_OP_FADD;
    req_a     = 32'h3F800000;
    req_b     = 32'h40000000;
    req_rd    = 5'd1;
    req_valid = 1'b1;
    pulses = 0; p1_n = -1; p2_n = -1; ctl_zero = 0;
    p1_rd = '0; p2_rd = '0; p1_data = '0; p2_data = '0;
    for (n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (wb_valid) begin
        pulses++;
        if (p1_n < 0) begin
          p1_n = n; p1_rd = wb_rd; p1_data = wb_data;
        end else if (p2_n < 0) begin
          p2_n = n; p2_rd = wb_rd; p2_data = wb_data;
        end
      end else if (p1_n > 0 && p2_n < 0 && fpu_ctl == 4'd0) begin
        ctl_zero++;
      end
      if (n == 1) begin
        req_a  = 32'h40000000;
        req_b  = 32'h40000000;
        req_rd = 5'd2;
      end
      if (n == 3) m_res = 32'h40800000;
      if (n == 5) req_valid = 1'b0;
    end
    check("b2b_pulse_count", pulses, 2);
    check("b2b_first_cycle", p1_n, 3);
    check("b2b_interval", p2_n - p1_n, 4);
    check("b2b_first_rd", {27'd0, p1_rd}, 32'd1);
    check("b2b_second_rd", {27'd0, p2_rd}, 32'd2);
    check("b2b_first_data", p1_data, 32'h40400000);
    check("b2b_second_data", p2_data, 32'h40800000);
    check("b2b_ctl_gap_seen", {31'd0, ctl_zero >= 1}, 32'd1);

    // Reset while ARMED: everything clears and the op is never written back.
    m_delay   = 1000;
    m_res     = 32'h11111111;
    req_op    = FPU_OP_FADD;
    req_a     = 32'h3F800000;
    req_b     = 32'h3F800000;
    req_rd    = 5'd12;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("armed_before_reset_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("rst_ctl_ops_zero", {28'd0, fpu_ctl} | fpu_x1 | fpu_x2, 32'd0);
    check("rst_wb_zero", {27'd0, wb_rd} | wb_data, 32'd0);
    check("rst_valid_busy_zero", {30'd0, wb_valid, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wb_valid || busy || fpu_ctl != 4'd0) bad++;
    end
    check("rst_op_dropped", bad, 0);

`ifdef FPU_ISSUE_TIMEOUT_EN
    // Timeout: fpu_ready never rises. 16 ARMED cycles elapse, so err is seen
    // 18 edges after acceptance (accept, ISSUE, then 16 ARMED edges).
    m_delay   = 1000;
    req_op    = FPU_OP_FADD;
    req_a     = 32'h40000000;
    req_b     = 32'h40000000;
    req_rd    = 5'd5;
    req_valid = 1'b1;
    pulses = 0; p1_n = -1; bad = 0;
    for (n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
      if (wb_valid) bad++;
      if (err) begin
        pulses++;
        if (p1_n < 0) begin
          p1_n = n;
          check("tmo_busy_dropped", {31'd0, busy}, 32'd0);
          check("tmo_ctl_released", {28'd0, fpu_ctl}, 32'd0);
        end
      end
    end
    check("tmo_err_pulses", pulses, 1);
    check("tmo_err_cycle", p1_n, 18);
    check("tmo_no_writeback", bad, 0);
    run_vec(vecs[2]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
